// File: rtl/key_pkg.sv
// Shared types for the key event decoder: FSM state encoding and event codes.
package key_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESSED,
    LONG_HELD,
    WAIT_SECOND,
    SECOND_PRESSED
  } key_state_t;

  localparam logic [2:0] EV_NONE   = 3'd0;
  localparam logic [2:0] EV_SHORT  = 3'd1;
  localparam logic [2:0] EV_LONG   = 3'd2;
  localparam logic [2:0] EV_REPEAT = 3'd3;
  localparam logic [2:0] EV_DOUBLE = 3'd4;

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: one-cycle tick every FREQ*1000 clocks, restartable via clr.
module ms_tick_gen #(
  parameter int FREQ = 50
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int TERM = FREQ * 1000 - 1;
  localparam int PW   = $clog2(TERM + 1);

  logic [PW-1:0] cnt;

  assign tick = (cnt == PW'(TERM));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + PW'(1);
    end
  end

endmodule

// File: rtl/key_event_decoder.sv
// Classifies debounced key press/release pulses into SHORT, LONG, REPEAT and
// DOUBLE events and offers them to the controller over a valid/ack handshake.
module key_event_decoder
  import key_pkg::*;
#(
  parameter int FREQ      = 50,
  parameter int LONG_MS   = 1000,
  parameter int DOUBLE_MS = 250,
  parameter int REPEAT_MS = 200,
  parameter int CW        = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_press,
  input  logic       key_release,
  output logic       event_valid,
  output logic [2:0] event_code,
  input  logic       event_ack,
  output logic       event_lost,
  output logic       key_busy
);

  // Thresholds fire on the tick that would take ms_cnt to the limit.
  localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_MS - 1);
  localparam logic [CW-1:0] DOUBLE_LAST = CW'(DOUBLE_MS - 1);
  localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_MS - 1);

  key_state_t    state;
  key_state_t    state_next;
  logic [CW-1:0] ms_cnt;
  logic          ms_tick;
  logic          lone_press;
  logic          lone_release;
  logic          state_change;
  logic          tick_clr;
  logic          long_hit;
  logic          repeat_hit;
  logic          double_hit;
  logic          emit;
  logic [2:0]    emit_code;
  logic          repeat_restart;

  assign lone_press   = key_press & ~key_release;
  assign lone_release = key_release & ~key_press;
  assign state_change = (state_next != state);
  assign tick_clr     = lone_press | lone_release | state_change;

  assign long_hit   = ms_tick && (ms_cnt == LONG_LAST);
  assign repeat_hit = ms_tick && (ms_cnt == REPEAT_LAST);
  assign double_hit = ms_tick && (ms_cnt == DOUBLE_LAST);

  ms_tick_gen #(
    .FREQ(FREQ)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (tick_clr),
    .tick (ms_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      key_busy <= 1'b0;
    end else begin
      state    <= state_next;
      key_busy <= (state_next != IDLE);
    end
  end

  // A pulse in the same cycle as a timeout wins, since ms_cnt is still below the limit.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:           if (lone_press) state_next = PRESSED;
      PRESSED: begin
        if (lone_release)  state_next = WAIT_SECOND;
        else if (long_hit) state_next = LONG_HELD;
      end
      LONG_HELD:      if (lone_release) state_next = IDLE;
      WAIT_SECOND: begin
        if (lone_press)      state_next = SECOND_PRESSED;
        else if (double_hit) state_next = IDLE;
      end
      SECOND_PRESSED: if (lone_release) state_next = IDLE;
      default:        state_next = IDLE;
    endcase
  end

  always_comb begin
    emit           = 1'b0;
    emit_code      = EV_NONE;
    repeat_restart = 1'b0;
    case (state)
      PRESSED: begin
        if (!lone_release && long_hit) begin
          emit      = 1'b1;
          emit_code = EV_LONG;
        end
      end
      LONG_HELD: begin
        if (!lone_release && repeat_hit) begin
          emit           = 1'b1;
          emit_code      = EV_REPEAT;
          repeat_restart = 1'b1;
        end
      end
      WAIT_SECOND: begin
        if (!lone_press && double_hit) begin
          emit      = 1'b1;
          emit_code = EV_SHORT;
        end
      end
      SECOND_PRESSED: begin
        if (lone_release) begin
          emit      = 1'b1;
          emit_code = EV_DOUBLE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ms_cnt <= '0;
    end else if (tick_clr || repeat_restart) begin
      ms_cnt <= '0;
    end else if (ms_tick && (ms_cnt != '1)) begin
      ms_cnt <= ms_cnt + CW'(1);
    end
  end

  // An ack in the same cycle as a new event frees the slot, so the new event is loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      event_valid <= 1'b0;
      event_code  <= EV_NONE;
      event_lost  <= 1'b0;
    end else if (emit) begin
      if (!event_valid || event_ack) begin
        event_valid <= 1'b1;
        event_code  <= emit_code;
        event_lost  <= 1'b0;
      end else begin
        event_lost <= 1'b1;
      end
    end else if (event_valid && event_ack) begin
      event_valid <= 1'b0;
      event_code  <= EV_NONE;
      event_lost  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_key_event_decoder.sv
// Bench for key_event_decoder: a directed step table for the timed corner
// cases, then random gestures compared every cycle against a behavioural model.
module tb_key_event_decoder;

  localparam int FREQ        = 1;
  localparam int LONG_MS     = 10;
  localparam int DOUBLE_MS   = 4;
  localparam int REPEAT_MS   = 3;
  localparam int CW          = 16;
  localparam int T           = FREQ * 1000;
  localparam int RAND_CYCLES = 18000;

  logic       clk         = 1'b0;
  logic       rst_n       = 1'b0;
  logic       key_press   = 1'b0;
  logic       key_release = 1'b0;
  logic       event_ack   = 1'b0;
  logic       event_valid;
  logic [2:0] event_code;
  logic       event_lost;
  logic       key_busy;

  int checks   = 0;
  int errors   = 0;
  int rand_cyc = 0;

  always #5 clk = ~clk;

  key_event_decoder #(
    .FREQ     (FREQ),
    .LONG_MS  (LONG_MS),
    .DOUBLE_MS(DOUBLE_MS),
    .REPEAT_MS(REPEAT_MS),
    .CW       (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_press  (key_press),
    .key_release(key_release),
    .event_valid(event_valid),
    .event_code (event_code),
    .event_ack  (event_ack),
    .event_lost (event_lost),
    .key_busy   (key_busy)
  );

  typedef struct {
    bit          press;
    bit          rel;
    bit          ack;
    bit          rst;
    int          wait_cycles;
    logic [5:0]  exp;
    string       name;
  } step_t;

  function automatic logic [5:0] outs(bit v, int code, bit lost, bit busy);
    return {v, 3'(code), lost, busy};
  endfunction

  function automatic step_t mk(bit p, bit r, bit a, bit rs, int w, logic [5:0] e, string n);
    step_t s;
    s.press = p; s.rel = r; s.ack = a; s.rst = rs;
    s.wait_cycles = w; s.exp = e; s.name = n;
    return s;
  endfunction

  // Model: one elapsed-cycle counter since the last restart, plus the gesture phase.
  bit m_valid, m_lost, m_active, m_down, m_second, m_long;
  int m_code, m_el, el_next, fire_code;
  bit lone_p, lone_r, fire;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 0; m_lost = 0; m_code = 0;
      m_active = 0; m_down = 0; m_second = 0; m_long = 0; m_el = 0;
    end else begin
      lone_p    = key_press && !key_release;
      lone_r    = key_release && !key_press;
      fire      = 0;
      fire_code = 0;
      el_next   = m_el + 1;
      m_el      = (lone_p || lone_r) ? 0 : el_next;
      if (!m_active) begin
        if (lone_p) begin
          m_active = 1; m_down = 1; m_second = 0; m_long = 0;
        end
      end else if (m_long) begin
        if (lone_r) m_active = 0;
        else if (el_next == REPEAT_MS * T) begin
          fire = 1; fire_code = 3; m_el = 0;
        end
      end else if (m_down && !m_second) begin
        if (lone_r) m_down = 0;
        else if (el_next == LONG_MS * T) begin
          fire = 1; fire_code = 2; m_long = 1; m_el = 0;
        end
      end else if (!m_down) begin
        if (lone_p) begin
          m_down = 1; m_second = 1;
        end else if (el_next == DOUBLE_MS * T) begin
          fire = 1; fire_code = 1; m_active = 0; m_el = 0;
        end
      end else if (lone_r) begin
        fire = 1; fire_code = 4; m_active = 0;
      end
      if (m_valid && event_ack) begin
        m_valid = 0; m_code = 0; m_lost = 0;
      end
      if (fire) begin
        if (m_valid) m_lost = 1;
        else begin
          m_valid = 1; m_code = fire_code;
        end
      end
    end
  end

  task automatic check_output(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got valid=%0b code=%0d lost=%0b busy=%0b, expected valid=%0b code=%0d lost=%0b busy=%0b",
               name, act[5], act[4:2], act[1], act[0], exp[5], exp[4:2], exp[1], exp[0]);
    end
  endtask

  task automatic apply_stimulus(input step_t s);
    key_press   = s.press;
    key_release = s.rel;
    event_ack   = s.ack;
    if (s.rst) rst_n = 1'b0;
    @(negedge clk);
    key_press   = 1'b0;
    key_release = 1'b0;
    event_ack   = 1'b0;
    rst_n       = 1'b1;
    repeat (s.wait_cycles) @(negedge clk);
    check_output(s.name, {event_valid, event_code, event_lost, key_busy}, s.exp);
  endtask

  task automatic run_cycle(input bit p, input bit r);
    key_press   = p;
    key_release = r;
    event_ack   = ($urandom_range(0, 1499) == 0);
    @(negedge clk);
    key_press   = 1'b0;
    key_release = 1'b0;
    event_ack   = 1'b0;
    rand_cyc++;
    check_output("model", {event_valid, event_code, event_lost, key_busy},
                 {m_valid, 3'(m_code), m_lost, m_active});
  endtask

  task automatic run_idle(input int n);
    for (int i = 0; i < n && rand_cyc < RAND_CYCLES; i++) run_cycle(1'b0, 1'b0);
  endtask

  initial begin
    step_t steps[$];
    steps.push_back(mk(0,0,0,0,    0, outs(0,0,0,0), "reset_state"));
    steps.push_back(mk(1,0,0,0, 2999, outs(0,0,0,1), "short_press_busy"));
    steps.push_back(mk(0,1,0,0, 3999, outs(0,0,0,1), "short_not_early"));
    steps.push_back(mk(0,0,0,0,    0, outs(1,1,0,0), "short_emit"));
    steps.push_back(mk(1,0,0,0, 9999, outs(1,1,0,1), "long_not_early"));
    steps.push_back(mk(0,0,0,0,    0, outs(1,1,1,1), "long_dropped"));
    steps.push_back(mk(0,1,0,0,    0, outs(1,1,1,0), "release_long_held"));
    steps.push_back(mk(0,0,1,0,    0, outs(0,0,0,0), "ack_clears"));
    steps.push_back(mk(0,0,1,0,    0, outs(0,0,0,0), "stray_ack"));
    steps.push_back(mk(1,0,0,0, 9999, outs(0,0,0,1), "long2_not_early"));
    steps.push_back(mk(0,0,0,0,    0, outs(1,2,0,1), "long_emit"));
    steps.push_back(mk(0,0,0,0, 2998, outs(1,2,0,1), "long_pending"));
    steps.push_back(mk(0,0,1,0,    0, outs(1,3,0,1), "ack_with_repeat"));
    steps.push_back(mk(0,0,1,0,    0, outs(0,0,0,1), "ack_repeat"));
    steps.push_back(mk(0,0,0,0, 2997, outs(0,0,0,1), "repeat2_not_early"));
    steps.push_back(mk(0,0,0,0,    0, outs(1,3,0,1), "repeat2_emit"));
    steps.push_back(mk(0,0,1,0,    0, outs(0,0,0,1), "ack_repeat2"));
    steps.push_back(mk(0,0,0,0,  997, outs(0,0,0,1), "hold_17ms"));
    steps.push_back(mk(0,1,0,0,    0, outs(0,0,0,0), "release_held"));
    steps.push_back(mk(0,0,0,0, 2999, outs(0,0,0,0), "quiet_after_hold"));
    steps.push_back(mk(1,0,0,0, 1999, outs(0,0,0,1), "double_first_hold"));
    steps.push_back(mk(0,1,0,0, 1999, outs(0,0,0,1), "double_gap"));
    steps.push_back(mk(1,0,0,0, 4999, outs(0,0,0,1), "second_hold"));
    steps.push_back(mk(0,1,0,0,    0, outs(1,4,0,0), "double_emit"));
    steps.push_back(mk(0,0,1,0,    0, outs(0,0,0,0), "ack_double"));
    steps.push_back(mk(1,0,0,0, 4999, outs(0,0,0,1), "press_before_reset"));
    steps.push_back(mk(0,0,0,1,    0, outs(0,0,0,0), "reset_mid_press"));
    steps.push_back(mk(0,1,0,0,    0, outs(0,0,0,0), "release_after_reset"));
    steps.push_back(mk(0,0,0,0, 4999, outs(0,0,0,0), "no_event_after_reset"));
    steps.push_back(mk(1,1,0,0,    9, outs(0,0,0,0), "both_pulses_ignored"));
    steps.push_back(mk(0,1,0,0,    0, outs(0,0,0,0), "idle_release_ignored"));

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < steps.size(); i++) apply_stimulus(steps[i]);

    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    while (rand_cyc < RAND_CYCLES) begin
      run_idle(int'($urandom_range(0, 5000)));
      run_cycle(1'b1, 1'b0);
      if ($urandom_range(0, 3) == 0) run_idle(int'($urandom_range(9000, 13500)));
      else                           run_idle(int'($urandom_range(50, 3900)));
      run_cycle(1'b0, 1'b1);
      if ($urandom_range(0, 1) == 1) begin
        run_idle(int'($urandom_range(50, 4500)));
        run_cycle(1'b1, 1'b0);
        run_idle(int'($urandom_range(50, 3000)));
        run_cycle(1'b0, 1'b1);
      end
      if ($urandom_range(0, 5) == 0) run_cycle(1'b1, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
